// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control around an external PC register.
// Produces pc_next for the PC register, runs the imem req/ready handshake,
// parks a fetched word in a one-entry skid buffer when decode stalls, and
// drains an in-flight request before following a redirect that arrived early.
module fetch_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      PC_INC   = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pc_current,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             ifid_valid,
  output logic [WIDTH-1:0] ifid_pc,
  output logic [WIDTH-1:0] ifid_instr
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } ifid_t;

  state_t           r_state, w_state_nxt;
  ifid_t            r_ifid, w_ifid_nxt;
  logic [WIDTH-1:0] r_skid_pc, w_skid_pc_nxt;
  logic [WIDTH-1:0] r_skid_instr, w_skid_instr_nxt;
  logic [WIDTH-1:0] r_saved_target, w_saved_nxt;
  logic [WIDTH-1:0] w_pc_inc, w_pc_nxt, w_drain_tgt;
  logic             w_req;

  assign w_pc_inc    = pc_current + WIDTH'(PC_INC);
  // A redirect arriving on the drain's final cycle is the newest one and wins.
  assign w_drain_tgt = redirect_valid ? redirect_target : r_saved_target;

  // State and IF/ID/skid registers; reset abandons any open transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_FETCH;
      r_ifid         <= '0;
      r_skid_pc      <= '0;
      r_skid_instr   <= '0;
      r_saved_target <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ifid         <= w_ifid_nxt;
      r_skid_pc      <= w_skid_pc_nxt;
      r_skid_instr   <= w_skid_instr_nxt;
      r_saved_target <= w_saved_nxt;
    end
  end

  // Next-state, next-PC and IF/ID update; default is hold PC and hold everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_ifid_nxt       = r_ifid;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_saved_nxt      = r_saved_target;
    w_pc_nxt         = pc_current;
    w_req            = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (imem_ready) begin
          if (redirect_valid) begin
            w_ifid_nxt.vld = 1'b0;
            w_pc_nxt       = redirect_target;
          end else if (!stall || !r_ifid.vld) begin
            w_ifid_nxt = '{vld: 1'b1, pc: pc_current, instr: imem_rdata};
            w_pc_nxt   = w_pc_inc;
          end else begin
            // Decode is full: keep the word, stop requesting until it drains.
            w_skid_pc_nxt    = pc_current;
            w_skid_instr_nxt = imem_rdata;
            w_state_nxt      = S_HOLD;
          end
        end else if (redirect_valid) begin
          // Request already presented; must finish it before moving the PC.
          w_ifid_nxt.vld = 1'b0;
          w_saved_nxt    = redirect_target;
          w_state_nxt    = S_DRAIN;
        end else if (!stall) begin
          w_ifid_nxt.vld = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_ifid_nxt.vld = 1'b0;
          w_pc_nxt       = redirect_target;
          w_state_nxt    = S_FETCH;
        end else if (!stall) begin
          w_ifid_nxt  = '{vld: 1'b1, pc: r_skid_pc, instr: r_skid_instr};
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        w_req          = 1'b1;
        w_ifid_nxt.vld = 1'b0;
        if (imem_ready) begin
          w_pc_nxt    = w_drain_tgt;
          w_state_nxt = S_FETCH;
        end else if (redirect_valid) begin
          w_saved_nxt = redirect_target;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign imem_req   = reset_n & w_req;
  assign imem_addr  = pc_current;
  assign pc_next    = reset_n ? w_pc_nxt : RESET_PC;
  assign ifid_valid = r_ifid.vld;
  assign ifid_pc    = r_ifid.pc;
  assign ifid_instr = r_ifid.instr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: external PC register, 0x100+addr memory, a
// transaction-level model checked every negedge, plus literal directed checks.
module tb_fetch_sequencer;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pc_current, pc_next, imem_addr, imem_rdata, redirect_target;
  logic [31:0] ifid_pc, ifid_instr;
  logic        imem_req, imem_ready, stall, redirect_valid, ifid_valid;

  int n_vec = 0;
  int n_bad = 0;

  fetch_sequencer dut (
    .clock(clock), .reset_n(reset_n), .pc_current(pc_current), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_instr(ifid_instr)
  );

  always #5 clock = ~clock;

  // PC register with no enable and no reset, as in the surrounding pipeline.
  always @(posedge clock) pc_current <= pc_next;

  assign imem_rdata = 32'h100 + imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: pending buffered word, pending drain, own PC ----
  logic [31:0] m_pc, m_p, m_i, m_bp, m_bi, m_tg;
  logic        m_v, m_buf, m_dr;
  logic [31:0] n_pc, n_p, n_i, n_bp, n_bi, n_tg;
  logic        n_v, n_buf, n_dr;
  bit          n_rst = 0, m_init = 0;
  logic [31:0] e_pc_next, e_p, e_i;
  logic        e_req, e_v;

  always @(negedge clock) begin
    logic [31:0] inc, rd, tgt;
    inc = m_pc + 32'd1;
    rd  = 32'h100 + m_pc;
    n_v = m_v; n_p = m_p; n_i = m_i; n_buf = m_buf; n_bp = m_bp; n_bi = m_bi;
    n_dr = m_dr; n_tg = m_tg; n_rst = 0;
    e_v = m_v; e_p = m_p; e_i = m_i; e_pc_next = m_pc; e_req = 1'b1;
    if (!reset_n) begin
      e_req = 0; e_pc_next = 0; e_v = 0; e_p = 0; e_i = 0;
      n_v = 0; n_p = 0; n_i = 0; n_buf = 0; n_bp = 0; n_bi = 0; n_dr = 0; n_tg = 0;
      n_rst = 1;
    end else if (m_buf) begin
      e_req = 0;
      if (redirect_valid) begin
        n_v = 0; n_buf = 0; e_pc_next = redirect_target;
      end else if (!stall) begin
        n_v = 1; n_p = m_bp; n_i = m_bi; n_buf = 0; e_pc_next = inc;
      end
    end else if (m_dr) begin
      n_v = 0;
      tgt = redirect_valid ? redirect_target : m_tg;
      if (imem_ready) begin e_pc_next = tgt; n_dr = 0; end
      else n_tg = tgt;
    end else begin
      if (redirect_valid) begin
        n_v = 0;
        if (imem_ready) e_pc_next = redirect_target;
        else begin n_dr = 1; n_tg = redirect_target; end
      end else if (imem_ready) begin
        if (!stall || !m_v) begin n_v = 1; n_p = m_pc; n_i = rd; e_pc_next = inc; end
        else begin n_buf = 1; n_bp = m_pc; n_bi = rd; end
      end else if (!stall) n_v = 0;
    end
    n_pc = e_pc_next;
    if (m_init) begin
      chk("m_imem_req", {31'd0, imem_req}, {31'd0, e_req});
      if (reset_n) chk("m_imem_addr", imem_addr, m_pc);
      chk("m_pc_next", pc_next, e_pc_next);
      chk("m_ifid_valid", {31'd0, ifid_valid}, {31'd0, e_v});
      if (e_v || !reset_n) begin
        chk("m_ifid_pc", ifid_pc, e_p);
        chk("m_ifid_instr", ifid_instr, e_i);
      end
    end
  end

  always @(posedge clock) begin
    m_pc = n_pc; m_v = n_v; m_p = n_p; m_i = n_i; m_buf = n_buf; m_bp = n_bp;
    m_bi = n_bi; m_dr = n_dr; m_tg = n_tg;
    if (n_rst) m_init = 1;
  end

  // ---------------- directed stimulus --------------------------------------
  task automatic cyc(input logic rdy, input logic stl, input logic rv, input logic [31:0] rt);
    @(posedge clock); #2;
    imem_ready = rdy; stall = stl; redirect_valid = rv; redirect_target = rt;
    #1;
  endtask

  initial begin
    reset_n = 0; imem_ready = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc_next", pc_next, 32'd0);
    @(posedge clock); #2; reset_n = 1; #1;
    chk("boot_addr", imem_addr, 32'd0);
    chk("boot_pc_next", pc_next, 32'd1);
    cyc(1, 0, 0, 0);
    chk("seq1_ifid_pc", ifid_pc, 32'd0); chk("seq1_ifid_instr", ifid_instr, 32'h100);
    chk("seq1_pc_next", pc_next, 32'd2);
    cyc(1, 0, 0, 0);
    chk("seq2_ifid_instr", ifid_instr, 32'h101);
    cyc(1, 0, 0, 0);
    chk("seq3_ifid_pc", ifid_pc, 32'd2); chk("seq3_addr", imem_addr, 32'd3);
    cyc(1, 0, 0, 0);
    // memory wait at pc 5
    cyc(0, 0, 0, 0);
    chk("wait_addr0", imem_addr, 32'd5); chk("wait_pcn0", pc_next, 32'd5);
    cyc(0, 0, 0, 0);
    chk("wait_bubble", {31'd0, ifid_valid}, 32'd0); chk("wait_addr1", imem_addr, 32'd5);
    cyc(0, 0, 0, 0);
    chk("wait_addr2", imem_addr, 32'd5);
    cyc(1, 0, 0, 0);
    chk("wait_addr3", imem_addr, 32'd5); chk("wait_pcn3", pc_next, 32'd6);
    cyc(1, 0, 0, 0);
    chk("wait_load_pc", ifid_pc, 32'd5); chk("wait_load_v", {31'd0, ifid_valid}, 32'd1);
    // stall with fetch of pc 7 completing
    cyc(1, 1, 0, 0);
    chk("stall_pcn", pc_next, 32'd7); chk("stall_ifid_pc", ifid_pc, 32'd6);
    cyc(1, 1, 0, 0);
    chk("hold_req", {31'd0, imem_req}, 32'd0); chk("hold_ifid_pc", ifid_pc, 32'd6);
    chk("hold_ifid_v", {31'd0, ifid_valid}, 32'd1);
    cyc(1, 0, 0, 0);
    chk("unstall_pcn", pc_next, 32'd8);
    // redirect coincident with ready
    cyc(1, 0, 1, 32'h40);
    chk("unstall_ifid_pc", ifid_pc, 32'd7); chk("unstall_ifid_instr", ifid_instr, 32'h107);
    chk("redir_pcn", pc_next, 32'h40);
    cyc(1, 0, 0, 0);
    chk("redir_flush", {31'd0, ifid_valid}, 32'd0); chk("redir_addr", imem_addr, 32'h40);
    cyc(1, 0, 1, 32'd9);
    chk("redir_ifid_instr", ifid_instr, 32'h140);
    // double redirect while pc 9 waits
    cyc(0, 0, 1, 32'h80);
    chk("drain_pcn0", pc_next, 32'd9);
    cyc(0, 0, 1, 32'hC0);
    chk("drain_addr1", imem_addr, 32'd9); chk("drain_req1", {31'd0, imem_req}, 32'd1);
    cyc(0, 0, 0, 0);
    chk("drain_addr2", imem_addr, 32'd9);
    cyc(1, 0, 0, 0);
    chk("drain_addr3", imem_addr, 32'd9); chk("drain_pcn3", pc_next, 32'hC0);
    cyc(1, 0, 0, 0);
    chk("drain_no_valid", {31'd0, ifid_valid}, 32'd0); chk("drain_addr4", imem_addr, 32'hC0);
    cyc(1, 0, 0, 0);
    chk("drain_ifid_pc", ifid_pc, 32'hC0);
    // reset in S_HOLD
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("hold2_req", {31'd0, imem_req}, 32'd0);
    reset_n = 0; #1;
    chk("rhold_v", {31'd0, ifid_valid}, 32'd0); chk("rhold_req", {31'd0, imem_req}, 32'd0);
    chk("rhold_pcn", pc_next, 32'd0);
    stall = 0; @(posedge clock); @(posedge clock); #2; reset_n = 1; #1;
    chk("rhold_addr", imem_addr, 32'd0);
    cyc(1, 0, 0, 0);
    chk("rhold_ifid_instr", ifid_instr, 32'h100);
    // reset in S_DRAIN
    cyc(0, 0, 1, 32'h55);
    cyc(0, 0, 0, 0);
    chk("rdrain_addr", imem_addr, 32'd2);
    reset_n = 0; #1;
    chk("rdrain_req", {31'd0, imem_req}, 32'd0); chk("rdrain_pcn", pc_next, 32'd0);
    @(posedge clock); #2; reset_n = 1; imem_ready = 1; #1;
    chk("rdrain_addr2", imem_addr, 32'd0);
    cyc(1, 0, 0, 0);
    chk("rdrain_ifid_pc", ifid_pc, 32'd0);
    // drain completing with a same-cycle redirect
    cyc(0, 0, 1, 32'h30);
    cyc(1, 0, 1, 32'h70);
    chk("drain_late_pcn", pc_next, 32'h70);
    // PC wrap
    cyc(1, 0, 1, 32'hFFFF_FFFF);
    chk("wrap_addr0", imem_addr, 32'h70);
    cyc(1, 0, 0, 0);
    chk("wrap_pcn", pc_next, 32'd0);
    cyc(1, 0, 0, 0);
    chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFF); chk("wrap_ifid_instr", ifid_instr, 32'hFF);
    chk("wrap_addr", imem_addr, 32'd0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    @(negedge clock); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
